// File: rtl/alu_share_pkg.sv
// Shared definitions for the two-port ALU sharing arbiter.
package alu_share_pkg;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_EXEC = 2'd1,
      S_RESP = 2'd2
   } state_e;

   localparam logic [2:0] OP_ADD = 3'b000;
   localparam logic [2:0] OP_OR  = 3'b010;
   localparam logic [2:0] OP_SUB = 3'b100;
   localparam logic [2:0] OP_SLT = 3'b110;

   localparam int NREQ = 2;

endpackage

// File: rtl/alu_share_arbiter_rr_arb2.sv
// Two-input round-robin grant. Purely combinational; the pointer
// register lives in the parent so it only moves on an accepted request.
module rr_arb2
   import alu_share_pkg::*;
(
   input  logic [NREQ-1:0] req_i,
   input  logic            rr_ptr_i,
   output logic [NREQ-1:0] gnt_o,
   output logic            gnt_id_o
);

   // Pointer breaks ties; a lone requester wins outright.
   always_comb begin
      gnt_id_o = 1'b0;
      gnt_o    = '0;
      if (req_i == 2'b11) begin
         gnt_id_o = rr_ptr_i;
      end else if (req_i[1]) begin
         gnt_id_o = 1'b1;
      end
      if (req_i != '0) begin
         gnt_o = gnt_id_o ? 2'b10 : 2'b01;
      end
   end

endmodule

// File: rtl/alu_share_arbiter.sv
// Shares one external combinational ALU between two requesters. Operands
// are registered for a full execute cycle and the result is registered
// and held until the addressed requester accepts it.
module alu_share_arbiter
   import alu_share_pkg::*;
#(
   parameter int WIDTH    = 32,
   parameter int HOLD_OPS = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [1:0]       req_valid,
   output logic [1:0]       req_ready,
   input  logic [2:0]       req_op0,
   input  logic [2:0]       req_op1,
   input  logic [WIDTH-1:0] req_a0,
   input  logic [WIDTH-1:0] req_b0,
   input  logic [WIDTH-1:0] req_a1,
   input  logic [WIDTH-1:0] req_b1,
   output logic [1:0]       resp_valid,
   input  logic [1:0]       resp_ready,
   output logic [WIDTH-1:0] resp_data,
   output logic             resp_zero,
   output logic             resp_id,
   output logic [2:0]       alu_ctr,
   output logic [WIDTH-1:0] alu_rs,
   output logic [WIDTH-1:0] alu_rt,
   input  logic [WIDTH-1:0] alu_out,
   input  logic             alu_zero,
   output logic             busy
);

   state_e           state_q, state_d;
   logic             rr_ptr_q;
   logic [2:0]       ctr_q;
   logic [WIDTH-1:0] rs_q, rt_q;
   logic [WIDTH-1:0] resp_data_q;
   logic             resp_zero_q;
   logic             resp_id_q;
   logic [1:0]       resp_valid_q;
   logic [1:0]       gnt;
   logic             gnt_id;
   logic             accept;

   rr_arb2 u_arb (
      .req_i    (req_valid),
      .rr_ptr_i (rr_ptr_q),
      .gnt_o    (gnt),
      .gnt_id_o (gnt_id)
   );

   assign accept = (state_q == S_IDLE) && (req_valid != 2'b00);

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next state: idle until a request, one execute cycle, then hold the
   // response until the addressed port takes it.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (req_valid != 2'b00) state_d = S_EXEC;
         S_EXEC:  state_d = S_RESP;
         S_RESP:  if (resp_ready[resp_id_q]) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Outputs: ready only while idle; ALU inputs optionally gated to zero
   // outside the execute cycle to avoid needless toggling in the ALU.
   always_comb begin
      req_ready = (state_q == S_IDLE) ? gnt : 2'b00;
      busy      = (state_q != S_IDLE);
      alu_ctr   = ctr_q;
      alu_rs    = rs_q;
      alu_rt    = rt_q;
      if ((HOLD_OPS == 0) && (state_q != S_EXEC)) begin
         alu_ctr = '0;
         alu_rs  = '0;
         alu_rt  = '0;
      end
   end

   // Operand latch on grant, result capture after execute, response clear
   // on accept by the addressed port.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rr_ptr_q     <= 1'b0;
         ctr_q        <= '0;
         rs_q         <= '0;
         rt_q         <= '0;
         resp_id_q    <= 1'b0;
         resp_data_q  <= '0;
         resp_zero_q  <= 1'b0;
         resp_valid_q <= 2'b00;
      end else begin
         if (accept) begin
            ctr_q     <= gnt_id ? req_op1 : req_op0;
            rs_q      <= gnt_id ? req_a1 : req_a0;
            rt_q      <= gnt_id ? req_b1 : req_b0;
            resp_id_q <= gnt_id;
            rr_ptr_q  <= ~gnt_id;
         end
         if (state_q == S_EXEC) begin
            resp_data_q  <= alu_out;
            resp_zero_q  <= alu_zero;
            resp_valid_q <= resp_id_q ? 2'b10 : 2'b01;
         end
         if ((state_q == S_RESP) && resp_ready[resp_id_q]) begin
            resp_valid_q <= 2'b00;
         end
      end
   end

   assign resp_valid = resp_valid_q;
   assign resp_data  = resp_data_q;
   assign resp_zero  = resp_zero_q;
   assign resp_id    = resp_id_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter with a behavioural ALU and a
// queue of expected responses.
module tb_alu_share_arbiter;
   import alu_share_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [1:0]  req_valid = 2'b00;
   logic [1:0]  req_ready;
   logic [2:0]  req_op0 = '0, req_op1 = '0;
   logic [31:0] req_a0 = '0, req_b0 = '0, req_a1 = '0, req_b1 = '0;
   logic [1:0]  resp_valid;
   logic [1:0]  resp_ready = 2'b00;
   logic [31:0] resp_data;
   logic        resp_zero;
   logic        resp_id;
   logic [2:0]  alu_ctr;
   logic [31:0] alu_rs, alu_rt;
   logic [31:0] alu_out;
   logic        alu_zero;
   logic        busy;

   typedef struct {
      logic        id;
      logic [2:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] data;
      logic        zero;
   } exp_t;

   exp_t sb[$];
   int   vectors = 0;
   int   miscompares = 0;

   alu_share_arbiter #(.WIDTH(32), .HOLD_OPS(1)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_op0    (req_op0),
      .req_op1    (req_op1),
      .req_a0     (req_a0),
      .req_b0     (req_b0),
      .req_a1     (req_a1),
      .req_b1     (req_b1),
      .resp_valid (resp_valid),
      .resp_ready (resp_ready),
      .resp_data  (resp_data),
      .resp_zero  (resp_zero),
      .resp_id    (resp_id),
      .alu_ctr    (alu_ctr),
      .alu_rs     (alu_rs),
      .alu_rt     (alu_rt),
      .alu_out    (alu_out),
      .alu_zero   (alu_zero),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   // Reference ALU sitting outside the block.
   always_comb begin
      alu_out = '0;
      case (alu_ctr[2:1])
         2'b00:   alu_out = alu_rs + alu_rt;
         2'b01:   alu_out = alu_rs | alu_rt;
         2'b10:   alu_out = alu_rs - alu_rt;
         default: alu_out = {31'd0, (alu_rs < alu_rt)};
      endcase
      alu_zero = (alu_out == 32'd0);
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic drive(input int p, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
      if (p == 0) begin
         req_op0 = op; req_a0 = a; req_b0 = b;
      end else begin
         req_op1 = op; req_a1 = a; req_b1 = b;
      end
      req_valid[p] = 1'b1;
   endtask

   // Wait for a grant, check it went to port p, record the expected result.
   task automatic grant(input int p, input bit push, input bit drop,
                        input logic [31:0] ed, input logic ez);
      bit         got = 1'b0;
      logic [1:0] m;
      exp_t       e;
      m = (p == 0) ? 2'b01 : 2'b10;
      for (int i = 0; i < 20 && !got; i++) begin
         #1;
         if (req_ready != 2'b00) got = 1'b1;
         else @(negedge clk);
      end
      if (!got) begin
         chk($sformatf("grant_timeout_p%0d", p), 32'd0, 32'd1);
      end else begin
         chk($sformatf("grant_mask_p%0d", p), 32'(req_ready), 32'(m));
         if (push) begin
            e.id   = (p != 0);
            e.op   = (p == 0) ? req_op0 : req_op1;
            e.a    = (p == 0) ? req_a0 : req_a1;
            e.b    = (p == 0) ? req_b0 : req_b1;
            e.data = ed;
            e.zero = ez;
            sb.push_back(e);
         end
         @(posedge clk);
         #1;
         if (drop) req_valid[p] = 1'b0;
      end
   endtask

   // Wait for the response, check latency, ALU inputs and result fields.
   task automatic collect(input int p, input bit chk_lat);
      int         n = 0;
      exp_t       e;
      logic [1:0] m;
      m = (p == 0) ? 2'b01 : 2'b10;
      while (resp_valid == 2'b00 && n < 10) begin
         @(negedge clk);
         #1;
         n++;
         if (chk_lat && n == 1 && sb.size() > 0) begin
            chk("exec_alu_ctr", 32'(alu_ctr), 32'(sb[0].op));
            chk("exec_alu_rs", alu_rs, sb[0].a);
            chk("exec_alu_rt", alu_rt, sb[0].b);
            chk("exec_busy", 32'(busy), 32'd1);
         end
      end
      if (chk_lat) chk("resp_latency", n, 2);
      if (resp_valid == 2'b00) begin
         chk("resp_timeout", 32'd0, 32'd1);
      end else if (sb.size() == 0) begin
         chk("resp_unexpected", 32'(resp_valid), 32'd0);
      end else begin
         e = sb.pop_front();
         chk("resp_valid", 32'(resp_valid), 32'(m));
         chk("resp_id", 32'(resp_id), 32'(e.id));
         chk("resp_data", resp_data, e.data);
         chk("resp_zero", 32'(resp_zero), 32'(e.zero));
      end
   endtask

   task automatic hold(input int n, input logic [31:0] ed, input logic [1:0] vm);
      for (int k = 0; k < n; k++) begin
         @(negedge clk);
         #1;
         chk("hold_data", resp_data, ed);
         chk("hold_valid", 32'(resp_valid), 32'(vm));
         chk("hold_no_ready", 32'(req_ready), 32'd0);
      end
   endtask

   task automatic release_resp(input int p);
      resp_ready[p] = 1'b1;
      @(posedge clk);
      #1;
      resp_ready[p] = 1'b0;
      chk("resp_clear", 32'(resp_valid), 32'd0);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      // Reset state
      repeat (2) @(negedge clk);
      #1;
      chk("rst_req_ready", 32'(req_ready), 32'd0);
      chk("rst_resp_valid", 32'(resp_valid), 32'd0);
      chk("rst_resp_data", resp_data, 32'd0);
      chk("rst_resp_zero", 32'(resp_zero), 32'd0);
      chk("rst_resp_id", 32'(resp_id), 32'd0);
      chk("rst_alu_ctr", 32'(alu_ctr), 32'd0);
      chk("rst_alu_rs", alu_rs, 32'd0);
      chk("rst_alu_rt", alu_rt, 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // Single request on port 0: 5 + 7
      drive(0, OP_ADD, 32'd5, 32'd7);
      grant(0, 1'b1, 1'b1, 32'd12, 1'b0);
      collect(0, 1'b1);
      release_resp(0);

      // Simultaneous requests after reset: port 0 first
      do_reset();
      drive(0, OP_SUB, 32'd9, 32'd9);
      drive(1, OP_SLT, 32'd3, 32'd8);
      grant(0, 1'b1, 1'b1, 32'd0, 1'b1);
      collect(0, 1'b1);
      release_resp(0);
      grant(1, 1'b1, 1'b1, 32'd1, 1'b0);
      collect(1, 1'b1);
      release_resp(1);

      // Fairness: both ports requesting continuously
      for (int r = 0; r < 4; r++) begin
         drive(0, OP_ADD, 32'(r), 32'd1);
         drive(1, OP_OR, 32'h100, 32'(r));
         if (r % 2 == 0) grant(0, 1'b1, 1'b0, 32'(r + 1), 1'b0);
         else            grant(1, 1'b1, 1'b0, 32'h100 | 32'(r), 1'b0);
         collect(r % 2, 1'b1);
         release_resp(r % 2);
      end
      req_valid = 2'b00;

      // Backpressure on port 1 with a competing port 0 request
      drive(1, OP_OR, 32'hF0, 32'h0F);
      grant(1, 1'b1, 1'b1, 32'hFF, 1'b0);
      collect(1, 1'b1);
      drive(0, OP_ADD, 32'd1, 32'd2);
      resp_ready[0] = 1'b1;
      hold(5, 32'hFF, 2'b10);
      resp_ready[0] = 1'b0;
      release_resp(1);
      chk("bp_p0_ready_after", 32'(req_ready), 32'd1);
      grant(0, 1'b1, 1'b1, 32'd3, 1'b0);
      collect(0, 1'b1);
      release_resp(0);

      // Wrap-around on add and sub
      drive(0, OP_ADD, 32'hFFFF_FFFF, 32'd1);
      grant(0, 1'b1, 1'b1, 32'd0, 1'b1);
      collect(0, 1'b1);
      release_resp(0);
      drive(0, OP_SUB, 32'd0, 32'd1);
      grant(0, 1'b1, 1'b1, 32'hFFFF_FFFF, 1'b0);
      collect(0, 1'b1);
      release_resp(0);

      // Reset during execute: result discarded, pointer back to port 0
      drive(0, OP_OR, 32'd1, 32'd2);
      grant(0, 1'b0, 1'b1, 32'd0, 1'b0);
      @(negedge clk);
      #1;
      chk("midrst_busy_before", 32'(busy), 32'd1);
      rst_n = 1'b0;
      #1;
      chk("midrst_busy", 32'(busy), 32'd0);
      chk("midrst_resp_valid", 32'(resp_valid), 32'd0);
      chk("midrst_req_ready", 32'(req_ready), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         #1;
         chk("postrst_no_resp", 32'(resp_valid), 32'd0);
         chk("postrst_idle", 32'(busy), 32'd0);
      end
      drive(0, OP_SUB, 32'd10, 32'd3);
      drive(1, OP_SLT, 32'd8, 32'd3);
      grant(0, 1'b1, 1'b1, 32'd7, 1'b0);
      collect(0, 1'b1);
      release_resp(0);
      grant(1, 1'b1, 1'b1, 32'd0, 1'b1);
      collect(1, 1'b1);
      release_resp(1);

      // Withdrawn request on port 1 while port 0 holds the grant
      drive(0, OP_OR, 32'd0, 32'd0);
      grant(0, 1'b1, 1'b1, 32'd0, 1'b1);
      req_valid[1] = 1'b1;
      @(posedge clk);
      #1;
      req_valid[1] = 1'b0;
      collect(0, 1'b0);
      release_resp(0);
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         #1;
         chk("withdrawn_no_grant", 32'(req_ready), 32'd0);
         chk("withdrawn_no_resp", 32'(resp_valid), 32'd0);
         chk("withdrawn_idle", 32'(busy), 32'd0);
      end
      chk("sb_drained", sb.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
